// File: rtl/bin2bcd_disp.sv
// bin2bcd_disp: 20-bit binary to six-digit BCD via double-dabble, with optional leading-zero blanking.
module bin2bcd_disp #(
  parameter int BLANK_CODE = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] value,
  input  logic        start,
  input  logic        blank_en,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5
);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam logic [3:0] BLANK = 4'(BLANK_CODE);
  state_t state;
  logic [19:0] bin;
  logic [23:0] bcd;
  logic [23:0] adj;
  logic [23:0] dig;
  logic [23:0] disp;
  logic [5:0] zero;
  logic [4:0] cnt;
  logic blank;
  // zero[k] is set when nibble k and every higher nibble are zero
  always_comb begin
    for (int i = 0; i < 6; i++) adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    zero[5] = bcd[23:20] == 4'd0;
    for (int i = 4; i >= 0; i--) zero[i] = zero[i+1] && bcd[4*i+:4] == 4'd0;
    for (int i = 0; i < 6; i++) dig[4*i+:4] = blank && i > 0 && zero[i] ? BLANK : bcd[4*i+:4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      bcd   <= '0;
      bin   <= '0;
      blank <= 1'b0;
      disp  <= {{5{BLANK}}, 4'd0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bin   <= value > 20'd999999 ? 20'd999999 : value;
          bcd   <= '0;
          cnt   <= '0;
          blank <= blank_en;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj[22:0], bin, 1'b0};
          cnt <= cnt + 5'd1;
          state <= cnt == 5'd19 ? FINISH : SHIFT;
        end
        FINISH: begin
          disp  <= dig;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign {digit5, digit4, digit3, digit2, digit1, digit0} = disp;
endmodule

// File: tb/tb_bin2bcd_disp.sv
// tb_bin2bcd_disp: randomized and directed checks of bin2bcd_disp against an arithmetic decimal model.
module tb_bin2bcd_disp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [19:0] value = '0;
  logic start = 1'b0;
  logic blank_en = 1'b0;
  logic busy, done;
  logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
  int total = 0;
  int bad = 0;
  logic [23:0] prev = 24'hAAAAA0;

  bin2bcd_disp #(.BLANK_CODE(10)) dut (
    .clk(clk), .reset(reset), .value(value), .start(start), .blank_en(blank_en),
    .busy(busy), .done(done),
    .digit0(digit0), .digit1(digit1), .digit2(digit2),
    .digit3(digit3), .digit4(digit4), .digit5(digit5)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] digits();
    return {digit5, digit4, digit3, digit2, digit1, digit0};
  endfunction

  // decimal digits by division; position i blanks when the number is below 10**i
  function automatic logic [23:0] model(input int unsigned v, input bit b);
    int unsigned s;
    int unsigned p;
    logic [23:0] r;
    s = v > 999999 ? 999999 : v;
    p = 1;
    for (int i = 0; i < 6; i++) begin
      r[4*i+:4] = 4'((s / p) % 10);
      if (b && i > 0 && s < p) r[4*i+:4] = 4'd10;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic convert(input logic [19:0] v, input logic b, output int lat,
                         output logic [23:0] mid, output logic [23:0] fin, output logic pulse_ok);
    value = v; blank_en = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; value = 20'($urandom); blank_en = 1'($urandom);
    lat = -1; mid = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 10) mid = digits();
      if (done) begin lat = k; break; end
    end
    fin = digits();
    @(posedge clk); #1;
    pulse_ok = !done && !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; value = 20'd5;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (digits() !== 24'hAAAAA0) begin bad++; $display("FAIL reset_digits got=%h want=aaaaa0", digits()); end
    prev = 24'hAAAAA0;
  endtask

  task automatic test_directed();
    logic [19:0] vs [6] = '{20'd12345, 20'd0, 20'd0, 20'd999999, 20'd1048575, 20'd100000};
    logic bs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [23:0] want [6] = '{24'hA12345, 24'hAAAAA0, 24'h000000, 24'h999999, 24'h999999, 24'h100000};
    int lat; logic [23:0] mid, fin; logic ok;
    for (int i = 0; i < 6; i++) begin
      convert(vs[i], bs[i], lat, mid, fin, ok);
      total++; if (lat != 21) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=21", i, lat); end
      total++; if (fin !== want[i]) begin bad++; $display("FAIL dir_digits[%0d] got=%h want=%h", i, fin, want[i]); end
      total++; if (mid !== prev) begin bad++; $display("FAIL dir_hold[%0d] got=%h want=%h", i, mid, prev); end
      total++; if (!ok) begin bad++; $display("FAIL dir_pulse[%0d] got=done/busy high want=low", i); end
      prev = want[i];
    end
  endtask

  task automatic test_random();
    int lat; logic [23:0] mid, fin, want; logic ok; logic [19:0] v; logic b;
    for (int i = 0; i < 20; i++) begin
      v = 20'($urandom) >> $urandom_range(0, 19);
      b = 1'($urandom);
      want = model(v, b);
      convert(v, b, lat, mid, fin, ok);
      total++; if (lat != 21) begin bad++; $display("FAIL rnd_latency v=%0d got=%0d want=21", v, lat); end
      total++; if (fin !== want) begin bad++; $display("FAIL rnd_digits v=%0d b=%b got=%h want=%h", v, b, fin, want); end
      total++; if (mid !== prev) begin bad++; $display("FAIL rnd_hold got=%h want=%h", mid, prev); end
      total++; if (!ok) begin bad++; $display("FAIL rnd_pulse v=%0d got=done/busy high want=low", v); end
      prev = want;
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0; int first = -1;
    value = 20'd42; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin value = 20'd7; blank_en = 1'b0; start = 1'b1; end
      if (k == 5) start = 1'b0;
      if (done) begin n_done++; if (first < 0) first = k; end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL ign_count got=%0d want=1", n_done); end
    total++; if (first != 21) begin bad++; $display("FAIL ign_latency got=%0d want=21", first); end
    total++; if (digits() !== 24'hAAAA42) begin bad++; $display("FAIL ign_digits got=%h want=aaaa42", digits()); end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    value = 20'd65535; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (k == 0) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy2 got=%b want=0", busy); end
      end
    end
    total++; if (n_done != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", n_done); end
    total++; if (digits() !== 24'hAAAAA0) begin bad++; $display("FAIL abort_digits got=%h want=aaaaa0", digits()); end
  endtask

  task automatic test_back_to_back();
    int dones [$];
    value = 20'd8; blank_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy0 got=%b want=1", busy); end
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk); #1;
      if (done) dones.push_back(k);
      total++; if (busy !== !done) begin bad++; $display("FAIL b2b_busy k=%0d got=%b want=%b", k, busy, !done); end
    end
    start = 1'b0;
    total++; if (dones.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", dones.size()); end
    else begin
      total++; if (dones[0] != 21 || dones[1] != 43) begin bad++; $display("FAIL b2b_edges got=%0d,%0d want=21,43", dones[0], dones[1]); end
    end
    total++; if (digits() !== 24'hAAAAA8) begin bad++; $display("FAIL b2b_digits got=%h want=aaaaa8", digits()); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2bcd_disp.md
BIN2BCD_DISP -- requirements
Module: bin2bcd_disp

Interface
REQ-001 The block SHALL have parameter BLANK_CODE, default 10, the digit code emitted for a blanked position (the code the downstream seven-segment decoder renders as all segments off).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port value, input, 20 bits, an unsigned binary number to display.
REQ-005 The block SHALL have port start, input, 1 bit, a conversion request that is sampled only in IDLE.
REQ-006 The block SHALL have port blank_en, input, 1 bit, which enables leading-zero blanking and is sampled together with value on start.
REQ-007 The block SHALL have port busy, output, 1 bit, which is high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a single-cycle pulse that is high when new digits become valid.
REQ-009 The block SHALL have ports digit0..digit5, output, 4 bits each, the decimal digits with digit0 as the least significant; each port SHALL drive one seven-segment decoder value input.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, SHIFT and FINISH.
REQ-011 In IDLE with start=1 at edge N, the block SHALL capture value and blank_en, enter SHIFT and set busy=1 after edge N.
REQ-012 If the captured value is greater than 999999, the block SHALL load 999999 into the shift register instead (saturation).
REQ-013 SHIFT SHALL perform shift-and-add-3 (double-dabble) over exactly 20 edges, N+1 through N+20.
- On each of those edges, every 4-bit BCD nibble that is 5 or greater SHALL have 3 added before the 1-bit left shift.
- The 24-bit BCD accumulator SHALL be cleared to 0 on the load.
REQ-014 A 5-bit counter SHALL track shift steps, and SHIFT SHALL exit to FINISH after the 20th shift.
REQ-015 At edge N+21 (FINISH), the block SHALL write digit0..digit5 from the accumulator, apply blanking, and assert done=1 and busy=0 for the following cycle, then return to IDLE.
REQ-016 Blanking SHALL apply only when the captured blank_en is 1.
- Each position k from 5 down to 1 SHALL output BLANK_CODE while it and all higher positions are zero.
- digit0 SHALL never be blanked.
REQ-017 The total latency SHALL be 21 cycles from the start-sampling edge to the done-asserting edge.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-020 start asserted in the cycle where done=1 SHALL be accepted, because the state is IDLE.
REQ-021 digit0..digit5 SHALL hold their last values unchanged throughout SHIFT and IDLE, and SHALL update only at FINISH.
REQ-022 Changes on value or blank_en after the capture edge SHALL NOT affect a conversion in progress.
REQ-023 A start held high continuously SHALL re-trigger a conversion every 22 cycles.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL apply all of the following, with reset taking priority over start:
- state set to IDLE;
- busy=0 and done=0;
- digit0=0 and digit1..digit5=BLANK_CODE;
- counter and accumulator cleared.
REQ-025 A reset asserted during SHIFT or FINISH SHALL abort the conversion and suppress done; the partial result SHALL never appear on the digit outputs.

Verification
REQ-026 Scenario: value=12345, blank_en=1, start pulse -> done exactly 21 edges later; digits5..0 = 10,1,2,3,4,5.
REQ-027 Scenario: value=0, blank_en=1 -> digits5..0 = 10,10,10,10,10,0; then value=0, blank_en=0 -> 0,0,0,0,0,0.
REQ-028 Scenario: value=999999 -> 9,9,9,9,9,9; value=1048575 -> 9,9,9,9,9,9 (saturation); value=100000, blank_en=1 -> 1,0,0,0,0,0.
REQ-029 Scenario: start at edge N with value=42, a second start with value=7 at N+5 -> single done at N+21; digits = 10,10,10,10,4,2.
REQ-030 Scenario: start with value=65535, reset at N+10 -> busy=0 at N+11, no done within 30 cycles, digits = 0 then five BLANK_CODE.
REQ-031 Scenario: start held high for 50 cycles with value=8 -> done pulses at N+21 and N+43; busy low only during the done cycles.
